// File: rtl/prefix_sub_8b_pipe.sv
`default_nettype none
// ============================================================================
// Module   : prefix_sub_8b_pipe
// Purpose  : 8-bit two's-complement subtractor (diff = a - b) built on a
//            Kogge-Stone parallel-prefix carry tree. The work is split over
//            three register stages with valid/ready handshakes on both
//            sides. The block also reports unsigned borrow, signed overflow
//            and zero flags.
// Ports    : clk, rst            - clock, synchronous active-high reset
//            in_valid/in_ready   - operand handshake (a = minuend, b = subtrahend)
//            out_valid/out_ready - result handshake
//            diff                - (a - b) mod 256
//            borrow              - 1 when a < b unsigned
//            ovf                 - signed overflow
//            zero                - 1 when diff == 0
// Revision : 1.0 - initial release
// ============================================================================
module prefix_sub_8b_pipe #(
  parameter int WIDTH      = 8,
  parameter int PIPE_DEPTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             ovf,
  output logic             zero
);

  // The datapath below is written for exactly 8 bits and three stages.
  generate
    if ((WIDTH != 8) || (PIPE_DEPTH != 3)) begin : g_bad_cfg
      $error("prefix_sub_8b_pipe supports only WIDTH=8 and PIPE_DEPTH=3");
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Handshake: each stage moves when it is empty or its successor moves.
  // --------------------------------------------------------------------------
  logic s1_valid, s2_valid, s3_valid;
  logic adv1, adv2, adv3;

  assign adv3      = ~s3_valid | out_ready;
  assign adv2      = ~s2_valid | adv3;
  assign adv1      = ~s1_valid | adv2;
  assign in_ready  = adv1;
  assign out_valid = s3_valid;

  // --------------------------------------------------------------------------
  // Stage 0 (combinational): generate/propagate of a + ~b
  // --------------------------------------------------------------------------
  logic [7:0] bn, g_in, p_in;

  assign bn   = ~b;
  assign g_in = a & bn;
  assign p_in = a ^ bn;

  logic [7:0] s1_p, s1_g;
  logic       s1_a7, s1_b7;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_p     <= 8'h00;
      s1_g     <= 8'h00;
      s1_a7    <= 1'b0;
      s1_b7    <= 1'b0;
    end else if (adv1) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_p  <= p_in;
        s1_g  <= g_in;
        s1_a7 <= a[7];
        s1_b7 <= b[7];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stage 1 -> 2: Kogge-Stone prefix tree, three combine levels.
  // The carry-in of 1 is folded into bit 0 so gk[3][i] is the carry out of
  // bit i. Group propagate of the last level is never needed, so only three
  // propagate levels exist.
  // --------------------------------------------------------------------------
  logic [3:0][7:0] gk;
  logic [2:0][7:0] pk;

  assign gk[0] = {s1_g[7:1], s1_g[0] | s1_p[0]};
  assign pk[0] = s1_p;

  genvar lvl, i;
  generate
    for (lvl = 0; lvl < 3; lvl++) begin : g_lvl
      for (i = 0; i < 8; i++) begin : g_bit
        if (i >= (1 << lvl)) begin : g_comb
          assign gk[lvl+1][i] = gk[lvl][i] | (pk[lvl][i] & gk[lvl][i-(1<<lvl)]);
          if (lvl < 2) begin : g_prop
            assign pk[lvl+1][i] = pk[lvl][i] & pk[lvl][i-(1<<lvl)];
          end
        end else begin : g_pass
          assign gk[lvl+1][i] = gk[lvl][i];
          if (lvl < 2) begin : g_prop
            assign pk[lvl+1][i] = pk[lvl][i];
          end
        end
      end
    end
  endgenerate

  logic [7:0] s2_c, s2_p;
  logic       s2_a7, s2_b7;

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_c     <= 8'h00;
      s2_p     <= 8'h00;
      s2_a7    <= 1'b0;
      s2_b7    <= 1'b0;
    end else if (adv2) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_c  <= gk[3];
        s2_p  <= s1_p;
        s2_a7 <= s1_a7;
        s2_b7 <= s1_b7;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stage 2 -> 3: sum XOR and flags. Bit 0 sees the carry-in of 1.
  // --------------------------------------------------------------------------
  logic [7:0] sum;
  logic       ovf_next;

  assign sum      = s2_p ^ {s2_c[6:0], 1'b1};
  assign ovf_next = (s2_a7 ^ s2_b7) & (sum[7] ^ s2_a7);

  // Output flops only load on a real result so the outputs stay frozen
  // while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      s3_valid <= 1'b0;
      diff     <= 8'h00;
      borrow   <= 1'b0;
      ovf      <= 1'b0;
      zero     <= 1'b0;
    end else if (adv3) begin
      s3_valid <= s2_valid;
      if (s2_valid) begin
        diff   <= sum;
        borrow <= ~s2_c[7];
        ovf    <= ovf_next;
        zero   <= ~|sum;
      end
    end
  end

endmodule
`default_nettype wire
